// File: rtl/sub_div_ctrl.sv
// Sequential unsigned restoring divider.
// One partial-remainder subtract step per clock; a zero divisor short-circuits
// straight to a flagged result without iterating.
module sub_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // acc starts as the dividend; each step consumes its MSB and appends a
    // quotient bit at the LSB, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   step;
    logic             no_borrow;
    logic [WIDTH-1:0] prem_nx;
    logic             last;

    // Subtract as P + (~D + 1) over WIDTH+1 bits; result packs the carry-out
    // (1 = no borrow, P >= D) above the low WIDTH difference bits. The bit at
    // position WIDTH is not needed: whenever there is no borrow the true
    // difference is below D and therefore fits in WIDTH bits.
    function automatic logic [WIDTH:0] sub_step(input logic [WIDTH:0]   pv,
                                                 input logic [WIDTH-1:0] dv);
        logic [WIDTH+1:0] sum;
        sum = {1'b0, pv} + {1'b0, ~{1'b0, dv}} + {{(WIDTH+1){1'b0}}, 1'b1};
        return {sum[WIDTH+1], sum[WIDTH-1:0]};
    endfunction

    // One restoring iteration: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted   = {prem, acc[WIDTH-1]};
        step      = sub_step(shifted, dsr);
        no_borrow = step[WIDTH];
        prem_nx   = no_borrow ? step[WIDTH-1:0] : shifted[WIDTH-1:0];
        last      = (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and result registers; results only change on a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            acc  <= dividend;
                            dsr  <= divisor;
                            prem <= '0;
                            cnt  <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc  <= {acc[WIDTH-2:0], no_borrow};
                    prem <= prem_nx;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        quotient    <= {acc[WIDTH-2:0], no_borrow};
                        remainder   <= prem_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/sub_div_ctrl.md
SUB_DIV_CTRL -- requirements
Module: sub_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division, sampled on the rising edge.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an accepted division is iterating.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port quotient, output, WIDTH bits: result of the last completed division.
REQ-010 SHALL have port remainder, output, WIDTH bits: remainder of the last completed division.
REQ-011 SHALL have port div_by_zero, output, 1 bit: flag marking the last completed division as divisor==0.

Function
REQ-012 SHALL implement an unsigned restoring divider by sequencing one WIDTH+1-bit subtract step per cycle.
REQ-013 SHALL form each subtract as the two's-complement sum P + (~D + 1), using no other subtraction form.
REQ-014 SHALL use the FSM states IDLE, RUN and DONE; register outputs only, with no combinational input-to-output path.
REQ-015 SHALL accept start when in IDLE or DONE (accepting edge = E0); start in RUN SHALL be ignored with no effect.
REQ-016 SHALL, on acceptance with divisor!=0: capture both operands, clear the partial remainder P, clear the iteration counter, and enter RUN.
REQ-017 SHALL, in RUN, perform one iteration per edge E1..E_WIDTH:
- shift the next dividend bit, MSB first, into P;
- compute T = P - divisor;
- if there is no borrow (carry-out = 1), set P = T and the quotient bit to 1;
- otherwise, keep P and set the quotient bit to 0.
REQ-018 SHALL, at edge E_WIDTH, load quotient and remainder, clear div_by_zero, and enter DONE; done is high for exactly the one cycle following E_WIDTH (latency WIDTH cycles).
REQ-019 SHALL, on acceptance with divisor==0, go directly to DONE at E0 with quotient = all ones, remainder = dividend and div_by_zero = 1; done is high for the cycle after E0.
REQ-020 SHALL hold busy = 1 exactly while in RUN.
REQ-021 SHALL leave DONE after one cycle, going to IDLE, or to RUN/DONE if start is accepted in that cycle (back-to-back operation).
REQ-022 SHALL hold quotient, remainder and div_by_zero stable between completions; changes on the operand inputs outside an accepting edge SHALL have no effect.
REQ-023 SHALL produce remainder < divisor and dividend == quotient*divisor + remainder for all divisor!=0.

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously force: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, internal counter and P cleared.
REQ-025 SHALL abort any in-flight division on reset with no done pulse; the first edge after deassertion SHALL behave as IDLE.

Verification
REQ-026 SHALL cover: dividend=200, divisor=7 -> quotient=28, remainder=4, done exactly 8 cycles after E0, busy high for 8 cycles.
REQ-027 SHALL cover: 255/1 -> q=255, r=0; and 5/9 -> q=0, r=5, div_by_zero=0.
REQ-028 SHALL cover: 0/0 and 77/0 -> done 1 cycle after E0, q=255, r equal to dividend, div_by_zero=1, busy never high.
REQ-029 SHALL cover: start re-pulsed with new operands during RUN -> ignored, result equals the first operation; start in the DONE cycle -> second result after another 8 cycles.
REQ-030 SHALL cover: rst_n pulled low at cycle 4 of RUN -> all outputs 0 immediately, no done pulse; the next division after release is correct.
REQ-031 SHALL cover: exhaustive or random sweep of all 65536 operand pairs checked against REQ-023 and the divide-by-zero rule.
